// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter/controller:
//   - state_e     : controller FSM states (IDLE, ISSUE, RESP)
//   - ALU_*       : ALUControl codes understood by the shared ALU
//   - FLAG_*      : bit positions inside the {N,Z,C,V} flag vector
//   - updates_cv(): true for the operations that define carry/overflow
// No ports (package).
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Only arithmetic operations produce meaningful carry/overflow.
    function automatic logic updates_cv(input logic [2:0] ctrl);
        return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_arbiter_ctrl_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with a one-bit last-grant register.
// A lone requester always wins; on a tie the requester not granted last wins.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (last grant := 1, so 0 wins first tie)
//   en_i   in   arbitration enable; no grant and no history update when low
//   req_i  in   [1:0] request vector
//   gnt_o  out  [1:0] one-hot (or zero) grant, combinational
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
            if (gnt_o != '0) begin
                last_d = gnt_o[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// alu_arbiter_ctrl
// Shares one combinational ALU between two requesters. A request is accepted
// in IDLE (req_ready pulse), its operands drive the ALU during ISSUE, and the
// captured result/flags are presented in RESP until rsp_ready is seen.
// Optional macro ALU_FLAGREG_EN: adds the architectural {N,Z,C,V} register
// (flags_q); without it flags_q is constant zero.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid[1:0]/req_ready    per-requester handshake
//   req_a/req_b[1:0][N-1:0]     per-requester operands
//   req_ctrl[1:0][2:0], req_s   per-requester ALUControl and set-flags bit
//   alu_a/alu_b/alu_ctrl        operands/control to the shared ALU
//   alu_result/alu_flags        combinational ALU result and {N,Z,C,V}
//   rsp_valid/rsp_ready         response handshake
//   rsp_id, rsp_result, rsp_flags  owner index and captured result/flags
//   flags_q                     architectural flag register
// ---------------------------------------------------------------------------
module alu_arbiter_ctrl
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0][N-1:0]   req_a,
    input  logic [1:0][N-1:0]   req_b,
    input  logic [1:0][2:0]     req_ctrl,
    input  logic [1:0]          req_s,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    output logic [2:0]          alu_ctrl,
    input  logic [N-1:0]        alu_result,
    input  logic [3:0]          alu_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [N-1:0]        rsp_result,
    output logic [3:0]          rsp_flags,
    output logic [3:0]          flags_q
);

    state_e       state_q, state_d;
    logic         arb_en;
    logic [1:0]   grant;

    logic [N-1:0] a_q, b_q;
    logic [2:0]   ctrl_q;
    logic         id_q;
    logic [N-1:0] res_q;
    logic [3:0]   rflags_q;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (arb_en),
        .req_i (req_valid),
        .gnt_o (grant)
    );

    always_comb begin
        state_d   = state_q;
        arb_en    = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Gate with rst so no accept pulse is shown while resetting.
                arb_en = !rst;
                if (grant != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = grant;

    // Operand registers feed the ALU directly, so they hold their last value
    // outside ISSUE instead of returning to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            id_q     <= 1'b0;
            res_q    <= '0;
            rflags_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant != '0) begin
                a_q    <= req_a[grant[1]];
                b_q    <= req_b[grant[1]];
                ctrl_q <= req_ctrl[grant[1]];
                id_q   <= grant[1];
            end
            if (state_q == ST_ISSUE) begin
                res_q    <= alu_result;
                rflags_q <= alu_flags;
            end
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_flags  = rflags_q;

`ifdef ALU_FLAGREG_EN
    logic       s_q;
    logic [3:0] flg_q, flg_d;

    always_comb begin
        flg_d = flg_q;
        if (state_q == ST_ISSUE && s_q) begin
            flg_d[FLAG_N] = alu_flags[FLAG_N];
            flg_d[FLAG_Z] = alu_flags[FLAG_Z];
            if (updates_cv(ctrl_q)) begin
                flg_d[FLAG_C] = alu_flags[FLAG_C];
                flg_d[FLAG_V] = alu_flags[FLAG_V];
            end
        end
    end

    // rst has priority, so an operation caught in ISSUE never updates flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 1'b0;
            flg_q <= '0;
        end else begin
            if (grant != '0) begin
                s_q <= req_s[grant[1]];
            end
            flg_q <= flg_d;
        end
    end

    assign flags_q = flg_q;
`else
    logic unused_req_s;
    assign unused_req_s = ^req_s;
    assign flags_q      = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter_ctrl
// Self-checking bench for alu_arbiter_ctrl. The bench also plays the shared
// ALU. A transaction-level reference model (busy flag + cycles since accept,
// last winner, flag vector) predicts every output each cycle; directed
// scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_alu_arbiter_ctrl;

    localparam int unsigned N = 32;

`ifdef ALU_FLAGREG_EN
    localparam logic [3:0] F_SUB = 4'b0110;
    localparam logic [3:0] F_AND = 4'b0110;
    localparam logic [3:0] F_NEG = 4'b1000;
`else
    localparam logic [3:0] F_SUB = 4'b0000;
    localparam logic [3:0] F_AND = 4'b0000;
    localparam logic [3:0] F_NEG = 4'b0000;
`endif

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   ctrl;
        logic         s;
    } op_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0][N-1:0]  req_a;
    logic [1:0][N-1:0]  req_b;
    logic [1:0][2:0]    req_ctrl;
    logic [1:0]         req_s;
    logic [N-1:0]       alu_a;
    logic [N-1:0]       alu_b;
    logic [2:0]         alu_ctrl;
    logic [N-1:0]       alu_result;
    logic [3:0]         alu_flags;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [N-1:0]       rsp_result;
    logic [3:0]         rsp_flags;
    logic [3:0]         flags_q;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .req_s      (req_s),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .flags_q    (flags_q)
    );

    // Reference ALU: returns {N,Z,C,V, result}.
    function automatic logic [N+3:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [2:0] ctrl);
        logic [N:0]   wide;
        logic [N-1:0] r;
        logic         c, v;
        wide = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (ctrl)
            3'b000: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[N-1:0];
                c    = wide[N];
                v    = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'b001: begin
                r = a - b;
                c = (a >= b);
                v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            default: r = a ^ b;
        endcase
        return {r[N-1], (r == '0), c, v, r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference model state.
    logic       m_busy = 1'b0;
    int         m_age = 0;
    logic       m_last = 1'b1;
    logic       m_id = 1'b0;
    logic [3:0] m_flags = 4'b0000;
    op_t        m_op = '0;
    logic [1:0] granted = 2'b00;

    // One clock: compare at the falling edge, advance the model at the rising
    // edge, return 1 time unit later so the caller can drive new inputs.
    task automatic tick();
        logic [1:0]   exp_rdy;
        logic [N+3:0] r;
        int           idx;
        @(negedge clk);
        exp_rdy = 2'b00;
        if (!rst && !m_busy) begin
            exp_rdy = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
        end
        r = alu_ref(m_op.a, m_op.b, m_op.ctrl);
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        check_eq("alu_a", 64'(alu_a), 64'(m_op.a));
        check_eq("alu_b", 64'(alu_b), 64'(m_op.b));
        check_eq("alu_ctrl", 64'(alu_ctrl), 64'(m_op.ctrl));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_age >= 2));
        if (m_busy && m_age >= 2) begin
            check_eq("rsp_id", 64'(rsp_id), 64'(m_id));
            check_eq("rsp_result", 64'(rsp_result), 64'(r[N-1:0]));
            check_eq("rsp_flags", 64'(rsp_flags), 64'(r[N+3:N]));
        end
        check_eq("flags_q", 64'(flags_q), 64'(m_flags));
        @(posedge clk);
        granted = exp_rdy;
        if (rst) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_last  = 1'b1;
            m_id    = 1'b0;
            m_flags = 4'b0000;
            m_op    = '0;
        end else if (exp_rdy != 2'b00) begin
            idx       = exp_rdy[1] ? 1 : 0;
            m_op.a    = req_a[idx];
            m_op.b    = req_b[idx];
            m_op.ctrl = req_ctrl[idx];
            m_op.s    = req_s[idx];
            m_id      = exp_rdy[1];
            m_last    = exp_rdy[1];
            m_busy    = 1'b1;
            m_age     = 1;
        end else if (m_busy) begin
            if (m_age == 1) begin
                m_age = 2;
`ifdef ALU_FLAGREG_EN
                if (m_op.s) begin
                    if (m_op.ctrl <= 3'd1) m_flags = r[N+3:N];
                    else m_flags[3:2] = r[N+3:N+2];
                end
`endif
            end else if (rsp_ready) begin
                m_busy = 1'b0;
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2:0] c, input logic s);
        req_valid[i] = 1'b1;
        req_a[i]     = a;
        req_b[i]     = b;
        req_ctrl[i]  = c;
        req_s[i]     = s;
    endtask

    function automatic logic [N-1:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            2:       return N'($urandom_range(0, 15));
            default: return N'($urandom);
        endcase
    endfunction

    task automatic rnd_req(input int i);
        set_req(i, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        req_s     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_rsp_id", 64'(rsp_id), 64'(0));
        check_eq("rst_rsp_result", 64'(rsp_result), 64'(0));
        check_eq("rst_rsp_flags", 64'(rsp_flags), 64'(0));
        check_eq("rst_alu_a", 64'(alu_a), 64'(0));
        check_eq("rst_alu_b", 64'(alu_b), 64'(0));
        check_eq("rst_alu_ctrl", 64'(alu_ctrl), 64'(0));
        check_eq("rst_flags_q", 64'(flags_q), 64'(0));
        req_valid = 2'b00;
        rst       = 1'b0;

        // Single ADD from requester 0: accept at t, response at t+2.
        set_req(0, 5, 3, 3'b000, 1'b1);
        tick();
        check_eq("add_gnt", 64'(granted), 64'(2'b01));
        req_valid = 2'b00;
        check_eq("add_issue_a", 64'(alu_a), 64'(5));
        tick();
        check_eq("add_valid", 64'(rsp_valid), 64'(1));
        check_eq("add_result", 64'(rsp_result), 64'(8));
        check_eq("add_id", 64'(rsp_id), 64'(0));
        check_eq("add_flags_q", 64'(flags_q), 64'(0));
        tick();

        // Both requesters always valid: round-robin 0,1,0 from reset.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rnd_req(0);
            rnd_req(1);
            tick();
            check_eq("rr_gnt", 64'(granted), (k == 1) ? 64'(2'b10) : 64'(2'b01));
            tick();
            check_eq("rr_id", 64'(rsp_id), 64'(k == 1));
            tick();
        end
        req_valid = 2'b00;

        // SUB 3-3 then AND 0xF0&0x0F: carry/overflow retained across AND.
        do_reset();
        set_req(0, 3, 3, 3'b001, 1'b1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check_eq("sub_flags_q", 64'(flags_q), 64'(F_SUB));
        tick();
        set_req(0, 32'hF0, 32'h0F, 3'b010, 1'b1);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check_eq("and_rsp_flags", 64'(rsp_flags), 64'(4'b0100));
        check_eq("and_flags_q", 64'(flags_q), 64'(F_AND));
        tick();

        // Response back-pressure with a pending request from requester 1.
        rsp_ready = 1'b0;
        rnd_req(0);
        tick();
        req_valid = 2'b00;
        rnd_req(1);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("hold_valid", 64'(rsp_valid), 64'(1));
            check_eq("hold_rdy", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        tick();
        tick();
        check_eq("hold_next_gnt", 64'(granted), 64'(2'b10));
        req_valid = 2'b00;
        repeat (3) tick();

        // Reset while the operation sits in ISSUE.
        set_req(0, 0, 0, 3'b000, 1'b1);
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_issue_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_issue_flags", 64'(flags_q), 64'(0));
        repeat (4) tick();

        // Negative ADD result: N appears in rsp_flags regardless of flag register.
        set_req(0, 32'h8000_0000, 32'h1, 3'b000, 1'b1);
        tick();
        req_valid = 2'b00;
        tick();
        check_eq("neg_rsp_n", 64'(rsp_flags[3]), 64'(1));
        check_eq("neg_flags_q", 64'(flags_q), 64'(F_NEG));
        tick();

        // Randomized traffic with occasional resets; requests hold until accepted.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst       = ($urandom_range(0, 99) == 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                if (granted[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 2) != 0) rnd_req(i);
                    else req_valid[i] = 1'b0;
                end
            end
        end
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
